// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, drives the program ROM address and registers the IF/ID pipeline latch.
// Define FETCH_PERF_COUNTERS_EN to build the fetch/stall performance counters.
module instruction_fetch_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEMORY_DEPTH = 128,
    parameter logic [DATA_WIDTH-1:0] PC_RESET = 32'h00400000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  BranchTaken,
    input  logic [DATA_WIDTH-1:0] BranchTarget,
    input  logic [DATA_WIDTH-1:0] InstructionIn,
    output logic [DATA_WIDTH-1:0] PCAddress,
    output logic [DATA_WIDTH-1:0] IFID_Instruction,
    output logic [DATA_WIDTH-1:0] IFID_PCPlus4,
    output logic                  IFID_Valid,
    output logic                  FetchFault,
    output logic [31:0]           FetchCount,
    output logic [31:0]           StallCount
);

    // One bit wider than an address so the window end cannot overflow.
    localparam logic [DATA_WIDTH:0] PcLimit =
        {1'b0, PC_RESET} + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

    typedef enum logic [1:0] {StBoot, StFetch, StHalt} state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic [DATA_WIDTH-1:0]   pcplus4_q, pcplus4_d;
    logic                    valid_q, valid_d;
    logic                    fault_q, fault_d;
    logic [DATA_WIDTH-1:0]   pc_plus4;
    logic                    deliver;
    logic                    stall_event;

    function automatic logic pc_legal(input logic [DATA_WIDTH-1:0] addr);
        return (addr[1:0] == 2'b00) && (addr >= PC_RESET) && ({1'b0, addr} < PcLimit);
    endfunction

    assign pc_plus4 = pc_q + DATA_WIDTH'(4);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pcplus4_d   = pcplus4_q;
        valid_d     = valid_q;
        fault_d     = fault_q;
        deliver     = 1'b0;
        stall_event = 1'b0;
        unique case (state_q)
            StBoot: begin
                state_d = StFetch;
                instr_d = '0;
                valid_d = 1'b0;
            end
            StFetch: begin
                if (BranchTaken) begin
                    // Wrong-path instruction is squashed whatever Stall/Flush say.
                    instr_d = '0;
                    valid_d = 1'b0;
                    if (pc_legal(BranchTarget)) begin
                        pc_d = BranchTarget;
                    end else begin
                        fault_d = 1'b1;
                        state_d = StHalt;
                    end
                end else if (Stall) begin
                    stall_event = 1'b1;
                    if (Flush) begin
                        instr_d = '0;
                        valid_d = 1'b0;
                    end
                end else begin
                    if (Flush) begin
                        instr_d = '0;
                        valid_d = 1'b0;
                    end else begin
                        instr_d   = InstructionIn;
                        pcplus4_d = pc_plus4;
                        valid_d   = 1'b1;
                        deliver   = 1'b1;
                    end
                    // The current instruction is still delivered if PC+4 leaves the window.
                    if (pc_legal(pc_plus4)) begin
                        pc_d = pc_plus4;
                    end else begin
                        fault_d = 1'b1;
                        state_d = StHalt;
                    end
                end
            end
            StHalt: begin
                instr_d = '0;
                valid_d = 1'b0;
            end
            default: begin
                state_d = StBoot;
                instr_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StBoot;
            pc_q      <= PC_RESET;
            instr_q   <= '0;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (deliver) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall_event) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign FetchCount = fetch_cnt_q;
    assign StallCount = stall_cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = deliver ^ stall_event;
    assign FetchCount = '0;
    assign StallCount = '0;
`endif

    assign PCAddress        = pc_q;
    assign IFID_Instruction = instr_q;
    assign IFID_PCPlus4     = pcplus4_q;
    assign IFID_Valid       = valid_q;
    assign FetchFault       = fault_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios plus random stimulus vs a behavioural model.
module tb_instruction_fetch_stage;

    localparam int unsigned DEPTH = 128;
    localparam logic [31:0] BASE = 32'h00400000;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall, Flush, BranchTaken;
    logic [31:0] BranchTarget, InstructionIn;
    logic [31:0] PCAddress, IFID_Instruction, IFID_PCPlus4;
    logic        IFID_Valid, FetchFault;
    logic [31:0] FetchCount, StallCount;

    int checks = 0;
    int passes = 0;

    logic [31:0] rom [DEPTH];
    logic [31:0] rom_off;

    // Model state
    logic [31:0] m_pc, m_instr, m_p4, m_fcnt, m_scnt;
    bit          m_valid, m_fault, m_halt, m_boot;

    instruction_fetch_stage #(
        .DATA_WIDTH  (32),
        .MEMORY_DEPTH(DEPTH),
        .PC_RESET    (BASE)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .Stall           (Stall),
        .Flush           (Flush),
        .BranchTaken     (BranchTaken),
        .BranchTarget    (BranchTarget),
        .InstructionIn   (InstructionIn),
        .PCAddress       (PCAddress),
        .IFID_Instruction(IFID_Instruction),
        .IFID_PCPlus4    (IFID_PCPlus4),
        .IFID_Valid      (IFID_Valid),
        .FetchFault      (FetchFault),
        .FetchCount      (FetchCount),
        .StallCount      (StallCount)
    );

    always #5 clk = ~clk;

    function automatic bit legal(input logic [31:0] a);
        longint unsigned v, lo, hi;
        v  = 64'(a);
        lo = 64'(BASE);
        hi = lo + 64'(4 * DEPTH);
        return (a[1:0] == 2'b00) && (v >= lo) && (v < hi);
    endfunction

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return rom[off[8:2]];
    endfunction

    always_comb begin
        rom_off = PCAddress - BASE;
        InstructionIn = 32'hDEADBEEF;
        if (legal(PCAddress)) InstructionIn = rom[rom_off[8:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else passes++;
    endtask

    task automatic compare_all();
        check("pc", PCAddress, m_pc);
        check("valid", 32'(IFID_Valid), 32'(m_valid));
        check("instr", IFID_Instruction, m_instr);
        if (m_valid) check("pcplus4", IFID_PCPlus4, m_p4);
        check("fault", 32'(FetchFault), 32'(m_fault));
`ifdef FETCH_PERF_COUNTERS_EN
        check("fetchcnt", FetchCount, m_fcnt);
        check("stallcnt", StallCount, m_scnt);
`else
        check("fetchcnt", FetchCount, 32'd0);
        check("stallcnt", StallCount, 32'd0);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_pc = BASE; m_instr = '0; m_p4 = '0; m_valid = 0; m_fault = 0;
        m_halt = 0; m_boot = 1; m_fcnt = '0; m_scnt = '0;
        check("reset_p4", IFID_PCPlus4, 32'd0);
        compare_all();
    endtask

    task automatic step(input bit s, input bit f, input bit b, input logic [31:0] t);
        logic [31:0] nxt;
        Stall = s; Flush = f; BranchTaken = b; BranchTarget = t;
        if (m_boot) begin
            m_boot = 0; m_valid = 0; m_instr = '0;
        end else if (m_halt) begin
            m_valid = 0; m_instr = '0;
        end else if (b) begin
            m_valid = 0; m_instr = '0;
            if (legal(t)) m_pc = t;
            else begin m_fault = 1; m_halt = 1; end
        end else if (s) begin
            m_scnt++;
            if (f) begin m_valid = 0; m_instr = '0; end
        end else begin
            nxt = m_pc + 32'd4;
            if (f) begin
                m_valid = 0; m_instr = '0;
            end else begin
                m_valid = 1; m_instr = rom_word(m_pc); m_p4 = nxt; m_fcnt++;
            end
            if (legal(nxt)) m_pc = nxt;
            else begin m_fault = 1; m_halt = 1; end
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        logic [31:0] tgt;
        reset = 1'b1; Stall = 0; Flush = 0; BranchTaken = 0; BranchTarget = '0;
        for (int i = 0; i < int'(DEPTH); i++)
            rom[i] = (i < 4) ? 32'h20080001 + 32'(i) : $urandom;

        // Free run from reset
        do_reset();
        step(0, 0, 0, '0);
        check("boot_valid", 32'(IFID_Valid), 32'd0);
        step(0, 0, 0, '0);
        check("first_instr", IFID_Instruction, 32'h20080001);
        check("first_p4", IFID_PCPlus4, 32'h00400004);
        step(0, 0, 0, '0);
        check("second_p4", IFID_PCPlus4, 32'h00400008);
        check("pc_at_8", PCAddress, 32'h00400008);
        for (int i = 0; i < 3; i++) step(1, 0, 0, '0);
        check("stall_pc", PCAddress, 32'h00400008);
        check("stall_instr", IFID_Instruction, 32'h20080002);
        step(0, 0, 0, '0);
        check("pc_at_c", PCAddress, 32'h0040000C);

        // Redirect under stall
        step(1, 0, 1, 32'h00400040);
        check("br_valid", 32'(IFID_Valid), 32'd0);
        check("br_pc", PCAddress, 32'h00400040);
        step(0, 0, 0, '0);
        check("br_p4", IFID_PCPlus4, 32'h00400044);

        // Flush together with stall
        step(0, 0, 1, 32'h0040000C);
        step(0, 0, 0, '0);
        step(1, 1, 0, '0);
        check("flush_pc", PCAddress, 32'h00400010);

        // Fault on misaligned target, then ignored inputs
        step(0, 0, 1, 32'h00400002);
        check("mis_fault", 32'(FetchFault), 32'd1);
        step(1, 1, 1, 32'h00400040);
        step(0, 0, 0, '0);
        check("halt_pc", PCAddress, 32'h00400010);
        do_reset();
        step(0, 0, 0, '0);
        step(0, 0, 1, 32'h00400200);
        check("oor_fault", 32'(FetchFault), 32'd1);
        step(0, 0, 0, '0);

        // Sequential run off the end of the ROM
        do_reset();
        for (int i = 0; i < 129; i++) step(0, 0, 0, '0);
        check("end_pc", PCAddress, 32'h004001FC);
        check("end_p4", IFID_PCPlus4, 32'h00400200);
        check("end_fault", 32'(FetchFault), 32'd1);
        step(0, 0, 0, '0);

        // Random traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0 || (m_halt && $urandom_range(0, 7) == 0)) begin
                Stall = 1'($urandom); BranchTaken = 1'($urandom); BranchTarget = $urandom;
                do_reset();
            end else begin
                case ($urandom_range(0, 9))
                    0: tgt = BASE + {23'd0, 7'($urandom_range(0, 127)), 2'b00} + 32'd1;
                    1: tgt = BASE + 32'h200 + {$urandom_range(0, 15), 2'b00};
                    2: tgt = $urandom;
                    default: tgt = BASE + {23'd0, 7'($urandom_range(0, 127)), 2'b00};
                endcase
                step($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
                     $urandom_range(0, 9) == 0, tgt);
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
